// File: rtl/prefetch_ctrl_pkg.sv
// Shared state encodings, fault codes and small helpers for the instruction prefetch controller.
// Fault states reuse the fault codes so a fault state is recognisable by a single compare.
package prefetch_ctrl_pkg;

  localparam logic [2:0] PREFETCH_MIN_FAULT = 3'd5;
  localparam logic [2:0] PREFETCH_GP_FAULT  = 3'd5;
  localparam logic [2:0] PREFETCH_PF_FAULT  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_STOP   = 3'd4,
    ST_FLT_GP = PREFETCH_GP_FAULT,
    ST_FLT_PF = PREFETCH_PF_FAULT
  } state_t;

  function automatic logic is_fault(input state_t s);
    return 3'(s) >= PREFETCH_MIN_FAULT;
  endfunction

  // Bytes from eip up to and including limit; 33 bits so a full 4 GiB segment fits.
  function automatic logic [32:0] bytes_to_limit(input logic [31:0] limit, input logic [31:0] eip);
    return {1'b0, limit} - {1'b0, eip} + 33'd1;
  endfunction

endpackage

// File: rtl/prefetch_ctrl_if.sv
// Instruction-cache request channel: one request in flight, completed by done or a page fault.
// The prefetch controller drives the master side, the icache the slave side.
interface prefetch_ctrl_if;
  logic        icache_req;
  logic [31:0] icache_address;
  logic [4:0]  icache_length;
  logic        icache_accept;
  logic        icache_done;
  logic        icache_pf;

  modport master (
    output icache_req, icache_address, icache_length,
    input  icache_accept, icache_done, icache_pf
  );

  modport slave (
    input  icache_req, icache_address, icache_length,
    output icache_accept, icache_done, icache_pf
  );
endinterface

// File: rtl/prefetch_len_calc.sv
// Request length: bytes to the end of the current line, clipped to the bytes left before the limit.
// Purely combinational.
module prefetch_len_calc #(
  parameter int LINE_BYTES = 16
) (
  input  logic [$clog2(LINE_BYTES)-1:0] offset,
  input  logic [32:0]                   left,
  output logic [4:0]                    length
);

  logic [32:0] room;

  assign room   = 33'(LINE_BYTES) - 33'(offset);
  assign length = (left < room) ? left[4:0] : room[4:0];

endmodule

// File: rtl/prefetch_ctrl.sv
// Prefetch sequencer: walks the code segment in line-sized icache requests, pushes GP/PF markers on faults.
// Requests need two free FIFO slots; a restart during an in-flight request flushes its completion.
module prefetch_ctrl
  import prefetch_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_BYTES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pr_reset,
  input  logic [31:0]          prefetch_eip,
  input  logic [31:0]          cs_base,
  input  logic [31:0]          cs_limit,
  input  logic [4:0]           prefetchfifo_used,
  prefetch_ctrl_if.master      icache,
  output logic                 prefetchfifo_limit_do,
  output logic                 prefetchfifo_pf_do,
  output logic                 prefetch_busy
);

  localparam int OFF_W = $clog2(LINE_BYTES);

  state_t      state, state_nxt;
  logic [31:0] linear;
  logic [32:0] left;
  logic [32:0] left_after;
  logic [4:0]  len_q;
  logic [4:0]  len_calc;
  logic        req_hold;
  logic        gp_pending;
  logic        restart_gp;
  logic        credit_ok;
  logic        fifo_space;
  logic        req_int;
  logic        limit_int;
  logic        pf_int;
  logic        busy_int;
  state_t      restart_state;

  prefetch_len_calc #(
    .LINE_BYTES (LINE_BYTES)
  ) u_len_calc (
    .offset (linear[OFF_W-1:0]),
    .left   (left),
    .length (len_calc)
  );

  assign restart_gp    = prefetch_eip > cs_limit;
  assign restart_state = restart_gp ? ST_FLT_GP : ST_REQ;
  assign credit_ok     = (32'(prefetchfifo_used) + 32'd2) <= 32'(FIFO_DEPTH);
  assign fifo_space    = 32'(prefetchfifo_used) < 32'(FIFO_DEPTH);
  assign left_after    = left - {28'd0, len_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (pr_reset) begin
      // A restart with a request in flight must still swallow that request's completion.
      state_nxt = (state == ST_WAIT || state == ST_FLUSH) ? ST_FLUSH : restart_state;
    end else begin
      case (state)
        ST_REQ: begin
          if (req_int && icache.icache_accept) state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (icache.icache_pf)        state_nxt = ST_FLT_PF;
          else if (icache.icache_done) state_nxt = (left_after == 33'd0) ? ST_FLT_GP : ST_REQ;
        end
        ST_FLUSH: begin
          if (icache.icache_done || icache.icache_pf) state_nxt = gp_pending ? ST_FLT_GP : ST_REQ;
        end
        default: begin
          if (is_fault(state) && fifo_space) state_nxt = ST_STOP;
        end
      endcase
    end
  end

  always_comb begin
    req_int   = 1'b0;
    limit_int = 1'b0;
    pf_int    = 1'b0;
    busy_int  = 1'b1;
    case (state)
      ST_REQ:           req_int  = !pr_reset && (credit_ok || req_hold);
      ST_IDLE, ST_STOP: busy_int = 1'b0;
      default:          ;
    endcase
    if (is_fault(state) && fifo_space && !pr_reset) begin
      limit_int = (state == ST_FLT_GP);
      pf_int    = (state == ST_FLT_PF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      linear     <= 32'd0;
      left       <= 33'd0;
      len_q      <= 5'd0;
      req_hold   <= 1'b0;
      gp_pending <= 1'b0;
    end else if (pr_reset) begin
      linear     <= cs_base + prefetch_eip;
      left       <= bytes_to_limit(cs_limit, prefetch_eip);
      gp_pending <= restart_gp;
      req_hold   <= 1'b0;
    end else begin
      // Once offered, a request is held even if FIFO credit later dips.
      if (state == ST_REQ) req_hold <= req_int && !icache.icache_accept;
      if (req_int && icache.icache_accept) len_q <= len_calc;
      if (state == ST_WAIT && icache.icache_done && !icache.icache_pf) begin
        linear <= linear + {27'd0, len_q};
        left   <= left_after;
      end
    end
  end

  assign icache.icache_req      = req_int;
  assign icache.icache_address  = linear;
  assign icache.icache_length   = len_calc;
  assign prefetchfifo_limit_do  = limit_int;
  assign prefetchfifo_pf_do     = pf_int;
  assign prefetch_busy          = busy_int;

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Self-checking bench for prefetch_ctrl: directed scenarios plus randomized restarts against a line/limit model.
module tb_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pr_reset;
  logic [31:0] eip, base, limit;
  logic [4:0]  used;
  logic        limit_do, pf_do, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int limit_cnt = 0;
  int pf_cnt    = 0;
  int req_cnt   = 0;

  prefetch_ctrl_if icache();

  prefetch_ctrl #(.FIFO_DEPTH(16), .LINE_BYTES(16)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .pr_reset              (pr_reset),
    .prefetch_eip          (eip),
    .cs_base               (base),
    .cs_limit              (limit),
    .prefetchfifo_used     (used),
    .icache                (icache),
    .prefetchfifo_limit_do (limit_do),
    .prefetchfifo_pf_do    (pf_do),
    .prefetch_busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (limit_do === 1'b1) limit_cnt++;
    if (pf_do === 1'b1) pf_cnt++;
    if (icache.icache_req === 1'b1) req_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    limit_cnt = 0;
    pf_cnt    = 0;
    req_cnt   = 0;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    pr_reset = 1'b0;
    used = 5'd0;
    icache.icache_accept = 1'b0;
    icache.icache_done = 1'b0;
    icache.icache_pf = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic restart(input logic [31:0] e, input logic [31:0] b, input logic [31:0] l);
    eip = e;
    base = b;
    limit = l;
    pr_reset = 1'b1;
    step();
    pr_reset = 1'b0;
  endtask

  // Waits for a request, captures it and accepts it.
  task automatic get_req(output logic [31:0] a, output logic [4:0] len);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (icache.icache_req === 1'b1) seen = 1'b1;
      else step();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL req_timeout: icache_req=%b, required 1 within 100 cycles", icache.icache_req);
    end
    a = icache.icache_address;
    len = icache.icache_length;
    icache.icache_accept = 1'b1;
    step();
    icache.icache_accept = 1'b0;
  endtask

  task automatic finish_req(input int delay, input bit with_pf);
    repeat (delay) step();
    icache.icache_done = 1'b1;
    icache.icache_pf = with_pf;
    step();
    icache.icache_done = 1'b0;
    icache.icache_pf = 1'b0;
  endtask

  function automatic logic [4:0] exp_len(input logic [31:0] a, input longint rem);
    longint room = 16 - longint'(a & 32'hF);
    return (rem < room) ? 5'(rem) : 5'(room);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    pr_reset = 1'b0;
    used = 5'd0;
    icache.icache_accept = 1'b0;
    icache.icache_done = 1'b0;
    icache.icache_pf = 1'b0;
    #1;
    n_checks++;
    if ({icache.icache_req, icache.icache_address, icache.icache_length, limit_do, pf_do, busy} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b addr=%h len=%0d lim=%b pf=%b busy=%b, required all 0",
               icache.icache_req, icache.icache_address, icache.icache_length, limit_do, pf_do, busy);
    end
    hard_reset();
    clear_counts();
    repeat (6) step();
    n_checks++;
    if (req_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_no_req: req cycles=%0d, required 0 before pr_reset", req_cnt);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [31:0] a;
    logic [4:0]  l;
    hard_reset();
    restart(32'h1000, 32'h10000, 32'hFFFF);
    get_req(a, l);
    n_checks++;
    if (a !== 32'h11000 || l !== 5'd16) begin
      n_fail++;
      $display("FAIL basic_first: addr=%h len=%0d, required 00011000 len 16", a, l);
    end
    finish_req(1, 1'b0);
    get_req(a, l);
    n_checks++;
    if (a !== 32'h11010 || l !== 5'd16) begin
      n_fail++;
      $display("FAIL basic_second: addr=%h len=%0d, required 00011010 len 16", a, l);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: busy=%b, required 1", busy);
    end
    finish_req(0, 1'b0);
  endtask

  task automatic test_limit();
    logic [31:0] a;
    logic [4:0]  l;
    hard_reset();
    clear_counts();
    restart(32'h0FFA, 32'h20000, 32'h1003);
    get_req(a, l);
    n_checks++;
    if (a !== 32'h20FFA || l !== 5'd6) begin
      n_fail++;
      $display("FAIL limit_first: addr=%h len=%0d, required 00020ffa len 6", a, l);
    end
    finish_req(0, 1'b0);
    get_req(a, l);
    n_checks++;
    if (a !== 32'h21000 || l !== 5'd4) begin
      n_fail++;
      $display("FAIL limit_second: addr=%h len=%0d, required 00021000 len 4", a, l);
    end
    used = 5'd16;
    finish_req(0, 1'b0);
    repeat (4) step();
    n_checks++;
    if (limit_cnt !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_fifo_full: pulses=%0d busy=%b, required 0 pulses busy 1", limit_cnt, busy);
    end
    used = 5'd3;
    repeat (3) step();
    n_checks++;
    if (limit_cnt !== 1 || pf_cnt !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_pulse: lim=%0d pf=%0d busy=%b, required 1 0 0", limit_cnt, pf_cnt, busy);
    end
  endtask

  task automatic test_credit();
    hard_reset();
    used = 5'd15;
    restart(32'h40, 32'h0, 32'hFFFF);
    clear_counts();
    repeat (5) step();
    n_checks++;
    if (req_cnt !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_block: req cycles=%0d busy=%b, required 0 and 1", req_cnt, busy);
    end
    used = 5'd14;
    step();
    n_checks++;
    if (icache.icache_req !== 1'b1 || icache.icache_address !== 32'h40) begin
      n_fail++;
      $display("FAIL credit_release: req=%b addr=%h, required 1 at 00000040", icache.icache_req, icache.icache_address);
    end
  endtask

  task automatic test_pf();
    logic [31:0] a;
    logic [4:0]  l;
    hard_reset();
    restart(32'h300, 32'h5000, 32'hFFFF);
    get_req(a, l);
    clear_counts();
    finish_req(0, 1'b1);
    repeat (3) step();
    n_checks++;
    if (pf_cnt !== 1 || limit_cnt !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pf_pulse: pf=%0d lim=%0d busy=%b, required 1 0 0", pf_cnt, limit_cnt, busy);
    end
    n_checks++;
    if (icache.icache_address !== 32'h5300) begin
      n_fail++;
      $display("FAIL pf_no_advance: addr=%h, required 00005300", icache.icache_address);
    end
    clear_counts();
    repeat (5) step();
    n_checks++;
    if (req_cnt !== 0) begin
      n_fail++;
      $display("FAIL stop_silent: req cycles=%0d, required 0", req_cnt);
    end
  endtask

  task automatic test_flush();
    logic [31:0] a;
    logic [4:0]  l;
    hard_reset();
    restart(32'h1000, 32'h30000, 32'hFFFF);
    get_req(a, l);
    restart(32'h2000, 32'h30000, 32'hFFFF);
    clear_counts();
    repeat (2) step();
    finish_req(0, 1'b0);
    n_checks++;
    if (req_cnt !== 0) begin
      n_fail++;
      $display("FAIL flush_quiet: req cycles=%0d, required 0", req_cnt);
    end
    get_req(a, l);
    n_checks++;
    if (a !== 32'h32000 || l !== 5'd16) begin
      n_fail++;
      $display("FAIL flush_next: addr=%h len=%0d, required 00032000 len 16", a, l);
    end
    restart(32'h9000, 32'h30000, 32'h8FFF);
    clear_counts();
    step();
    finish_req(0, 1'b0);
    repeat (3) step();
    n_checks++;
    if (limit_cnt !== 1 || req_cnt !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_gp: lim=%0d req=%0d busy=%b, required 1 0 0", limit_cnt, req_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    logic [4:0]  l;
    hard_reset();
    restart(32'h100, 32'hABC00, 32'hFFFF);
    get_req(a, l);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({icache.icache_req, icache.icache_address, icache.icache_length, limit_do, pf_do, busy} !== 40'd0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b addr=%h len=%0d lim=%b pf=%b busy=%b, required all 0",
               icache.icache_req, icache.icache_address, icache.icache_length, limit_do, pf_do, busy);
    end
    step();
    rst_n = 1'b1;
    step();
    clear_counts();
    restart(32'h500, 32'h0, 32'h4FF);
    repeat (4) step();
    n_checks++;
    if (limit_cnt !== 1 || req_cnt !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL eip_over_limit: lim=%0d req=%0d busy=%b, required 1 0 0", limit_cnt, req_cnt, busy);
    end
  endtask

  task automatic test_big_limit();
    logic [31:0] a, a_exp;
    logic [4:0]  l, l_exp;
    longint      rem;
    hard_reset();
    clear_counts();
    restart(32'h0, 32'h12345678, 32'hFFFFFFFF);
    a_exp = 32'h12345678;
    rem = longint'(1) << 32;
    for (int i = 0; i < 4; i++) begin
      get_req(a, l);
      l_exp = exp_len(a_exp, rem);
      n_checks++;
      if (a !== a_exp || l !== l_exp) begin
        n_fail++;
        $display("FAIL big_limit[%0d]: addr=%h len=%0d, required %h len %0d", i, a, l, a_exp, l_exp);
      end
      finish_req(0, 1'b0);
      a_exp = a_exp + 32'(l_exp);
      rem = rem - longint'(l_exp);
    end
    n_checks++;
    if (limit_cnt !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL big_limit_run: lim=%0d busy=%b, required 0 and 1", limit_cnt, busy);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, a_exp, e, b, lim;
    logic [4:0]  l, l_exp;
    longint      rem;
    hard_reset();
    for (int it = 0; it < 40; it++) begin
      e = $urandom & 32'h7FFF_FFFF;
      b = $urandom;
      lim = e + 32'($urandom_range(0, 70));
      used = 5'($urandom_range(0, 14));
      clear_counts();
      restart(e, b, lim);
      a_exp = b + e;
      rem = longint'(lim) - longint'(e) + 1;
      while (rem > 0) begin
        get_req(a, l);
        l_exp = exp_len(a_exp, rem);
        n_checks++;
        if (a !== a_exp || l !== l_exp) begin
          n_fail++;
          $display("FAIL random[%0d]: addr=%h len=%0d, required %h len %0d", it, a, l, a_exp, l_exp);
        end
        finish_req(int'($urandom_range(0, 3)), 1'b0);
        a_exp = a_exp + 32'(l_exp);
        rem = rem - longint'(l_exp);
      end
      repeat (3) step();
      n_checks++;
      if (limit_cnt !== 1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL random_end[%0d]: lim=%0d busy=%b, required 1 and 0", it, limit_cnt, busy);
      end
    end
  endtask

  initial begin
    eip = 32'd0;
    base = 32'd0;
    limit = 32'd0;
    test_reset();
    test_basic();
    test_limit();
    test_credit();
    test_pf();
    test_flush();
    test_reset_mid();
    test_big_limit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_ctrl.md
PREFETCH_CTRL -- requirements
Module: prefetch_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, SHALL set the prefetch FIFO entry count used for credit checks.
REQ-002 Parameter LINE_BYTES, default 16, SHALL set the maximum bytes per icache request; it SHALL be a power of two.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 pr_reset  in  1  pipeline restart; prefetch_eip, cs_base and cs_limit are valid in the same cycle.
REQ-006 prefetch_eip  in  32  restart EIP.
REQ-007 cs_base  in  32  code segment base.
REQ-008 cs_limit  in  32  code segment limit, inclusive.
REQ-009 prefetchfifo_used  in  5  current FIFO occupancy.
REQ-010 icache_req  out  1  request valid.
REQ-011 icache_address  out  32  linear address of the request.
REQ-012 icache_length  out  5  byte count, 1..LINE_BYTES.
REQ-013 icache_accept  in  1  request taken this cycle.
REQ-014 icache_done  in  1  data for the outstanding request pushed to the FIFO.
REQ-015 icache_pf  in  1  outstanding request terminated by a page fault.
REQ-016 prefetchfifo_limit_do  out  1  one-cycle push of a GP-fault marker entry.
REQ-017 prefetchfifo_pf_do  out  1  one-cycle push of a PF-fault marker entry.
REQ-018 prefetch_busy  out  1  high in any state except IDLE and STOP.

Function
REQ-019 States SHALL be IDLE, REQ, WAIT, FLUSH, FLT_GP, FLT_PF and STOP.
REQ-020 Registers: linear[31:0]; left[32:0] = bytes remaining to the limit.
REQ-021 pr_reset from IDLE, REQ, STOP, FLT_GP or FLT_PF: linear <= cs_base + prefetch_eip (mod 2^32); left <= {1'b0,cs_limit} - prefetch_eip + 1; next state REQ, or FLT_GP if prefetch_eip > cs_limit.
REQ-022 pr_reset in WAIT SHALL load linear and left as in REQ-021 and go to FLUSH; in FLUSH it SHALL reload them and stay in FLUSH.
REQ-023 FLUSH SHALL wait for icache_done or icache_pf, discard it, then go to REQ, or FLT_GP if the latest restart EIP exceeded its limit.
REQ-024 REQ: icache_req SHALL be 1 only when FIFO_DEPTH - prefetchfifo_used >= 2.
REQ-025 icache_length = min(LINE_BYTES - linear[3:0], left), computed combinationally; icache_address = linear.
REQ-026 icache_req and icache_address SHALL stay stable until icache_accept; an accept moves the FSM to WAIT and latches the length.
REQ-027 WAIT + icache_done: linear += length (wrap at 2^32), left -= length; next state FLT_GP if the new left == 0, else REQ.
REQ-028 WAIT + icache_pf SHALL go to FLT_PF; icache_pf has priority over a simultaneous icache_done.
REQ-029 FLT_GP and FLT_PF SHALL assert their push output for exactly one cycle once prefetchfifo_used < FIFO_DEPTH, then go to STOP.
REQ-030 STOP and IDLE SHALL issue nothing until pr_reset.
REQ-031 left = 2^32 (cs_limit = 0xFFFFFFFF, EIP = 0) SHALL be representable without overflow.
REQ-032 pr_reset SHALL take priority over every other event in the same cycle.
REQ-033 At most one icache request SHALL be outstanding.

Reset
REQ-034 On rst_n = 0: state IDLE, linear = 0, left = 0, and all outputs 0, asynchronously.
REQ-035 The first request after reset SHALL require a pr_reset.

Structure
REQ-036 The fault codes (PREFETCH_GP_FAULT, PREFETCH_PF_FAULT, PREFETCH_MIN_FAULT) and the state encodings SHALL live in the shared defines.
REQ-037 The length computation SHALL be one sub-module, prefetch_len_calc (linear[3:0], left -> length).

Verification
REQ-038 Restart with eip = 0x1000, base = 0x10000, limit = 0xFFFF -> request address 0x11000, length 16; after done the next address is 0x11010.
REQ-039 Restart with eip = 0x0FFA, limit = 0x1003 -> lengths 6, 4; then prefetchfifo_limit_do pulses once and the FSM enters STOP.
REQ-040 With prefetchfifo_used = 15 (depth 16) -> icache_req stays 0; at used = 14 -> icache_req rises next cycle.
REQ-041 icache_pf and icache_done asserted together in WAIT -> single prefetchfifo_pf_do pulse, STOP, linear unchanged.
REQ-042 pr_reset in WAIT to eip = 0x2000, then done 3 cycles later -> no advance; the next request is at base + 0x2000.
REQ-043 rst_n asserted mid-WAIT -> all outputs 0 immediately; eip > limit at restart -> limit pulse with no icache_req.
